// File: rtl/seq_pkg.sv
// Shared types and constants for the datapath sequencer:
// opcodes, ALU op codes, FSM states, IR field positions, control bundle.
package seq_pkg;

    typedef enum logic [3:0] {
        OP_ADDI = 4'h8,
        OP_LI   = 4'h9,
        OP_BR   = 4'hA,
        OP_HALT = 4'hF
    } opcode_e;

    localparam logic [3:0] ALU_ADD = 4'h0;
    localparam logic [3:0] ALU_BR  = 4'h8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_HALT
    } state_e;

    localparam int OP_HI = 15;
    localparam int OP_LO = 12;
    localparam int RS_HI = 11;
    localparam int RS_LO = 9;
    localparam int RT_HI = 8;
    localparam int RT_LO = 6;
    localparam int RD_HI = 5;
    localparam int RD_LO = 3;

    typedef struct packed {
        logic [3:0] alu_op;
        logic       src1;
        logic       src2;
        logic [2:0] rd0;
        logic [2:0] rd1;
        logic [2:0] wr;
        logic       we;
        logic       br;
        logic       halt;
        logic       ovf_en;
    } ctrl_t;

endpackage

// File: rtl/seq_decoder.sv
// Combinational instruction decoder: IR -> ALU/regfile control bundle.
// Ports: i_ir (instruction), o_ctrl (controls), o_imm (sign-extended imm).
module seq_decoder
    import seq_pkg::*;
#(
    parameter int IMM_W = 6
) (
    input  logic [15:0] i_ir,
    output ctrl_t       o_ctrl,
    output logic [15:0] o_imm
);

    logic [3:0] w_opc;
    logic [2:0] w_rs;
    logic [2:0] w_rt;
    logic [2:0] w_rd;

    assign w_opc = i_ir[OP_HI:OP_LO];
    assign w_rs  = i_ir[RS_HI:RS_LO];
    assign w_rt  = i_ir[RT_HI:RT_LO];
    assign w_rd  = i_ir[RD_HI:RD_LO];

    assign o_imm = {{(16-IMM_W){i_ir[IMM_W-1]}}, i_ir[IMM_W-1:0]};

    always_comb begin
        o_ctrl = '0;
        if (!w_opc[3]) begin
            o_ctrl.alu_op = w_opc;
            o_ctrl.rd0    = w_rs;
            o_ctrl.rd1    = w_rt;
            o_ctrl.wr     = w_rd;
            o_ctrl.we     = 1'b1;
            o_ctrl.ovf_en = 1'b1;
        end else begin
            case (w_opc)
                OP_ADDI: begin
                    o_ctrl.alu_op = ALU_ADD;
                    o_ctrl.src2   = 1'b1;
                    o_ctrl.rd0    = w_rs;
                    o_ctrl.wr     = w_rt;
                    o_ctrl.we     = 1'b1;
                    o_ctrl.ovf_en = 1'b1;
                end
                OP_LI: begin
                    // src1=1 selects constant zero, so result = imm
                    o_ctrl.alu_op = ALU_ADD;
                    o_ctrl.src1   = 1'b1;
                    o_ctrl.src2   = 1'b1;
                    o_ctrl.wr     = w_rt;
                    o_ctrl.we     = 1'b1;
                    o_ctrl.ovf_en = 1'b1;
                end
                OP_BR: begin
                    o_ctrl.alu_op = ALU_BR;
                    o_ctrl.rd0    = w_rs;
                    o_ctrl.rd1    = w_rt;
                    o_ctrl.br     = 1'b1;
                end
                OP_HALT: o_ctrl.halt = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/datapath_sequencer.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/WB FSM, pc, IR.
// Ports: clk/reset, start/stop, imem bus, ALU flags in, ALU/regfile
// controls out, busy/halted/ovf_sticky status.
module datapath_sequencer
    import seq_pkg::*;
#(
    parameter int PC_W  = 8,
    parameter int IMM_W = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            stop,
    output logic [PC_W-1:0] imem_addr,
    input  logic [15:0]     imem_rdata,
    input  logic            alu_take_branch,
    input  logic            alu_ovf,
    output logic [3:0]      ALUOp,
    output logic            ALUSrc1,
    output logic            ALUSrc2,
    output logic            RegWrite,
    output logic [2:0]      rd0_addr,
    output logic [2:0]      rd1_addr,
    output logic [2:0]      wr_addr,
    output logic [15:0]     imm_out,
    output logic            busy,
    output logic            halted,
    output logic            ovf_sticky
);

    state_e          r_state;
    logic [PC_W-1:0] r_pc;
    logic [15:0]     r_ir;
    logic            r_take;
    logic            r_we;
    logic            r_ovf;

    ctrl_t           w_ctrl;
    logic [15:0]     w_imm;
    logic [PC_W-1:0] w_pc_inc;
    logic [PC_W-1:0] w_pc_br;

    seq_decoder #(.IMM_W(IMM_W)) u_dec (
        .i_ir   (r_ir),
        .o_ctrl (w_ctrl),
        .o_imm  (w_imm)
    );

    // Modulo-2^PC_W arithmetic wraps naturally in both directions
    assign w_pc_inc = r_pc + PC_W'(1);
    assign w_pc_br  = w_pc_inc + PC_W'(w_imm);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_pc    <= '0;
            r_ir    <= '0;
            r_take  <= 1'b0;
            r_we    <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_HALT: begin
                    if (start) begin
                        r_state <= S_FETCH;
                        r_pc    <= '0;
                        r_ovf   <= 1'b0;
                    end
                end
                S_FETCH: r_state <= S_DECODE;
                S_DECODE: begin
                    r_ir    <= imem_rdata;
                    r_state <= S_EXEC;
                end
                S_EXEC: begin
                    r_take <= alu_take_branch;
                    if (alu_ovf && w_ctrl.ovf_en) r_ovf <= 1'b1;
                    r_we    <= w_ctrl.we;
                    r_state <= S_WB;
                end
                S_WB: begin
                    r_we <= 1'b0;
                    r_pc <= (w_ctrl.br && r_take) ? w_pc_br : w_pc_inc;
                    r_state <= (stop || w_ctrl.halt) ? S_HALT : S_FETCH;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign imem_addr  = r_pc;
    assign ALUOp      = w_ctrl.alu_op;
    assign ALUSrc1    = w_ctrl.src1;
    assign ALUSrc2    = w_ctrl.src2;
    assign rd0_addr   = w_ctrl.rd0;
    assign rd1_addr   = w_ctrl.rd1;
    assign wr_addr    = w_ctrl.wr;
    assign imm_out    = w_imm;
    assign RegWrite   = r_we;
    assign ovf_sticky = r_ovf;
    assign busy       = (r_state == S_FETCH) || (r_state == S_DECODE) ||
                        (r_state == S_EXEC)  || (r_state == S_WB);
    assign halted     = (r_state == S_HALT);

endmodule

// File: doc/datapath_sequencer.md
DATAPATH_SEQUENCER -- requirements
Module: datapath_sequencer

Interface
REQ-001 Parameter PC_W, default 8: instruction address width.
REQ-002 Parameter IMM_W, default 6: immediate field width, sign-extended to 16 bits.
REQ-003 Port clk  input  1  single clock for all state; rising-edge.
REQ-004 Port reset  input  1  asynchronous, active-high; clears all state.
REQ-005 Port start  input  1  one-cycle pulse; begins execution at pc=0.
REQ-006 Port stop  input  1  level; requests halt at the next instruction boundary.
REQ-007 Port imem_addr  output  PC_W  instruction memory address (equals pc).
REQ-008 Port imem_rdata  input  16  instruction word; synchronous ROM, valid one cycle after imem_addr.
REQ-009 Port alu_take_branch, alu_ovf  input  1 each  ALU status flags.
REQ-010 Port ALUOp  output  4, ALUSrc1 / ALUSrc2  output  1 each, RegWrite  output  1  ALU and regfile controls.
REQ-011 Port rd0_addr, rd1_addr, wr_addr  output  3 each  regfile addresses.
REQ-012 Port imm_out  output  16  sign-extended immediate for ALUSrc2 mux input b.
REQ-013 Port busy, halted, ovf_sticky  output  1 each  status.

Function
REQ-014 Instruction format: [15:12] opcode, [11:9] rs, [8:6] rt, [5:3] rd, [5:0] imm.
REQ-015 Opcodes 0x0-0x7 are R-type: ALUOp=opcode, ALUSrc1=0, ALUSrc2=0, rd0=rs, rd1=rt, write rd.
REQ-016 Opcode 0x8 ADDI: ALUOp=ALU_ADD, ALUSrc2=1, rd0=rs, write rt.
REQ-017 Opcode 0x9 LI: ALUOp=ALU_ADD, ALUSrc1=1 (zero), ALUSrc2=1, write rt.
REQ-018 Opcode 0xA BR: ALUOp=ALU_BR, rd0=rs, rd1=rt, no write; if alu_take_branch=1 in EXEC, next pc=pc+1+sext(imm), else pc+1.
REQ-019 Opcode 0xF HALT: no write; go to HALT. Opcodes 0xB-0xE are NOP: no write, pc+1.
REQ-020 FSM states IDLE, FETCH, DECODE, EXEC, WB, HALT.
REQ-021 IDLE: start=1 -> FETCH, pc=0, ovf_sticky cleared.
REQ-022 FETCH: drive imem_addr=pc -> DECODE. DECODE: latch imem_rdata into IR -> EXEC.
REQ-023 EXEC: controls driven from IR; sample alu_take_branch and alu_ovf -> WB.
REQ-024 WB: RegWrite=1 for exactly this one cycle for writing opcodes; controls and addresses held equal to their EXEC values; pc updated.
REQ-025 WB exit: next state HALT if stop=1 or opcode=HALT, else FETCH.
REQ-026 HALT: start=1 -> FETCH at pc=0 with ovf_sticky cleared; otherwise remain.
REQ-027 Latency: 4 cycles per instruction (FETCH, DECODE, EXEC, WB); the first FETCH is the cycle after start.
REQ-028 pc arithmetic is modulo 2^PC_W: 255+1 wraps to 0; branch target wraps both directions.
REQ-029 ovf_sticky is set when alu_ovf=1 in EXEC of opcodes 0x0-0x9; it is never set by BR or NOP.
REQ-030 start while busy is ignored; stop in IDLE or HALT has no effect.
REQ-031 RegWrite is 0 in every state other than WB.
REQ-032 busy=1 in FETCH, DECODE, EXEC and WB; halted=1 only in HALT.

Reset
REQ-033 Reset forces IDLE, pc=0, IR=0, ovf_sticky=0, RegWrite=0, ALUOp=0, ALUSrc1/2=0, all addresses 0, imm_out=0, busy=0, halted=0.
REQ-034 Reset asserted mid-instruction (including WB) deasserts RegWrite immediately and without a clock edge; the interrupted instruction has no further effect.

Structure
REQ-035 Package seq_pkg holds the opcode enum, ALU_ADD/ALU_BR constants, the FSM state enum, and the field-position constants.
REQ-036 One sub-module, seq_decoder, maps IR to controls combinationally; the FSM and pc stay in datapath_sequencer.

Verification
REQ-037 Reset release, start pulse, ROM[0]=LI r1,5 (0x9045) -> cycle 4 WB: RegWrite=1, wr_addr=1, ALUSrc1=1, ALUSrc2=1, imm_out=0x0005.
REQ-038 ROM[0]=BR imm=-1 with alu_take_branch forced 1 -> pc sequence 0,0,0 (loops); forced 0 -> pc advances to 1.
REQ-039 ROM: NOP at pc=255 -> next FETCH imem_addr=0.
REQ-040 stop raised during EXEC of the instruction at pc=3 -> that WB completes; next state HALT with halted=1, pc=4; start -> FETCH at pc=0.
REQ-041 alu_ovf=1 during ADD EXEC -> ovf_sticky=1 and remains 1 through a later NOP; new start clears it.
REQ-042 reset asserted in WB cycle -> RegWrite=0 in the same cycle; state IDLE; busy=0.
